// File: rtl/traceback_3d_pkg.sv
// Shared types for the 3-D alignment traceback: move masks and FSM states.
// A move mask is {di,dj,dk}; a set bit means that coordinate steps down by one.
package traceback_3d_pkg;

    typedef logic [2:0] move_t;

    localparam move_t MV_M   = 3'b111;
    localparam move_t MV_IX  = 3'b100;
    localparam move_t MV_IY  = 3'b010;
    localparam move_t MV_IZ  = 3'b001;
    localparam move_t MV_IXY = 3'b110;
    localparam move_t MV_IXZ = 3'b101;
    localparam move_t MV_IYZ = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/traceback_3d_if.sv
// Request, pointer-memory read, column-stream and status signals of traceback_3d.
// The master modport is the traceback engine; slave is its environment.
interface traceback_3d_if
    import traceback_3d_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 8
);
    logic             start;
    logic [IDX_W-1:0] end_i;
    logic [IDX_W-1:0] end_j;
    logic [IDX_W-1:0] end_k;

    logic             rd_req;
    logic [IDX_W-1:0] rd_i;
    logic [IDX_W-1:0] rd_j;
    logic [IDX_W-1:0] rd_k;
    logic             rd_valid;
    move_t            rd_ptr;

    logic             step_valid;
    logic             step_ready;
    move_t            step_move;
    logic             step_last;

    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        input  start, end_i, end_j, end_k, rd_valid, rd_ptr, step_ready,
        output rd_req, rd_i, rd_j, rd_k, step_valid, step_move, step_last,
               busy, done, err, step_cnt
    );

    modport slave (
        output start, end_i, end_j, end_k, rd_valid, rd_ptr, step_ready,
        input  rd_req, rd_i, rd_j, rd_k, step_valid, step_move, step_last,
               busy, done, err, step_cnt
    );

endinterface

// File: rtl/traceback_3d.sv
// Walks a 3-D pointer memory from an end cell back to (0,0,0), emitting one
// move mask per alignment column and flagging pointers that would underflow.
module traceback_3d
    import traceback_3d_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    traceback_3d_if.master bus
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | rd_req held at current cell until rd_valid
    // EMIT  | column offered downstream until step_ready
    // FIN   | one-cycle done (and err) pulse

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ci_q, ci_d, cj_q, cj_d, ck_q, ck_d;
    move_t            move_q, move_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] ni, nj, nk;
    logic             zero_after;

    function automatic logic ptr_legal(input move_t p, input logic [IDX_W-1:0] i,
                                       input logic [IDX_W-1:0] j, input logic [IDX_W-1:0] k);
        return (p != 3'b000) && !(p[2] && (i == '0)) && !(p[1] && (j == '0))
               && !(p[0] && (k == '0));
    endfunction

    assign ni = ci_q - {{(IDX_W-1){1'b0}}, move_q[2]};
    assign nj = cj_q - {{(IDX_W-1){1'b0}}, move_q[1]};
    assign nk = ck_q - {{(IDX_W-1){1'b0}}, move_q[0]};
    assign zero_after = (ni == '0) && (nj == '0) && (nk == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ci_q    <= '0;
            cj_q    <= '0;
            ck_q    <= '0;
            move_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ci_q    <= ci_d;
            cj_q    <= cj_d;
            ck_q    <= ck_d;
            move_q  <= move_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ci_d    = ci_q;
        cj_d    = cj_q;
        ck_d    = ck_q;
        move_d  = move_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ci_d    = bus.end_i;
                    cj_d    = bus.end_j;
                    ck_d    = bus.end_k;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ((bus.end_i == '0) && (bus.end_j == '0) && (bus.end_k == '0))
                              ? ST_FIN : ST_READ;
                end
            end
            ST_READ: begin
                if (bus.rd_valid) begin
                    if (ptr_legal(bus.rd_ptr, ci_q, cj_q, ck_q)) begin
                        move_d  = bus.rd_ptr;
                        state_d = ST_EMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_EMIT: begin
                if (bus.step_ready) begin
                    ci_d    = ni;
                    cj_d    = nj;
                    ck_d    = nk;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = zero_after ? ST_FIN : ST_READ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.rd_req     = (state_q == ST_READ);
    assign bus.rd_i       = ci_q;
    assign bus.rd_j       = cj_q;
    assign bus.rd_k       = ck_q;
    assign bus.step_valid = (state_q == ST_EMIT);
    assign bus.step_move  = move_q;
    assign bus.step_last  = (state_q == ST_EMIT) && zero_after;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_FIN);
    assign bus.err        = (state_q == ST_FIN) && err_q;
    assign bus.step_cnt   = cnt_q;

endmodule
